vec_controller: RTL
===================

# vec_controller

Parametrised vector successor to the single-shot DSP instruction controller. It accepts one instruction plus base addresses and an element count, then runs a read → DSP execute → write-back sequence once per element over BRAM0/BRAM1 with auto-incrementing addresses. It sits between the AXI-lite instruction registers and the BRAM/DSP48 datapath, and is used when a whole buffer must be processed per software kick.

## Interface
- ADDR_W, 10: BRAM port-B address width.
- LEN_W, 8: width of the element-count input; maximum vlen is 2^LEN_W−1.
- DSP_LAT, 3: cycles spent in EXE per element; legal range ≥1.
- WE_W, 4: BRAM1 byte-write-enable width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  level start/hold; held high until valid, then dropped.
- inst  in  32  instruction: [31] exec flag, [30:27] alumode, [26:20] opmode, [19:15] inmode; [14:0] ignored.
- src0_base  in  ADDR_W  first BRAM0 read address.
- src1_base  in  ADDR_W  first BRAM1 read address.
- dst_base  in  ADDR_W  first BRAM1 write address.
- vlen  in  LEN_W  number of elements.
- busy  out  1  high in READ/EXE/WRITE.
- valid  out  1  high in DONE.
- elem_idx  out  LEN_W  index of the current element (0-based).
- bram0_raddrb  out  ADDR_W;  bram0_enb  out  1.
- bram1_addrb  out  ADDR_W;  bram1_web  out  WE_W;  bram1_enb  out  1.
- dsp_alumode  out  4;  dsp_opmode  out  7;  dsp_inmode  out  5.

## Operation
- States: IDLE, READ, EXE, WRITE, DONE.
- On reset, or in IDLE: all outputs are 0. Internal instruction, base, length, index and latency counters are also 0.
- IDLE with en=1: capture inst[30:0], src0_base, src1_base, dst_base and vlen.
  - If inst[31]=1 and vlen≠0, go to READ.
  - Otherwise go straight to DONE; no BRAM or DSP activity occurs.
- READ (1 cycle):
  - bram0_enb=1, bram0_raddrb = src0_base + elem_idx.
  - bram1_enb=1, bram1_web=0, bram1_addrb = src1_base + elem_idx.
- EXE (exactly DSP_LAT cycles):
  - dsp_* driven from the captured fields; they are 0 in every other state.
  - The latency counter counts 0..DSP_LAT−1, then clears.
- WRITE (1 cycle):
  - bram1_enb=1, bram1_web = all ones, bram1_addrb = dst_base + elem_idx.
  - If elem_idx = vlen−1, go to DONE. Otherwise increment elem_idx and go to READ.
- DONE: valid=1, and it holds while en=1. en=0 returns to IDLE, which clears elem_idx.
- Address arithmetic is modulo 2^ADDR_W: base+idx wraps silently past the top of the BRAM.
- Abort: en=0 in READ, EXE or WRITE forces IDLE on the next edge.
  - A WRITE already in progress in that cycle completes; no further accesses are issued.
  - valid is never asserted for an aborted run.
- Inputs other than en are sampled only in IDLE; changes during a run are ignored.
- Asynchronous reset mid-run forces IDLE immediately, with all outputs 0, and no further BRAM enables.

## Timing
- The cycle in which IDLE samples en=1 is cycle 0. Cycle 1 is READ.
- Each element takes 2 + DSP_LAT cycles: READ at cycle 1 + k·(2+DSP_LAT), WRITE at (k+1)·(2+DSP_LAT).
- valid rises at cycle vlen·(2+DSP_LAT)+1.
- Skip path (inst[31]=0 or vlen=0): valid rises at cycle 1.
- After en falls, valid drops and IDLE is entered on the next edge. A new en=1 is accepted one cycle later.
- All BRAM and DSP outputs are decoded combinationally from the registered state and counters; there are no output registers.

## Test plan
- DSP_LAT=3, inst=0x8000_0000|fields, src0=0x010, src1=0x020, dst=0x030, vlen=3.
  - Required: READ addresses 0x010/0x020, 0x011/0x021, 0x012/0x022.
  - Required: WRITE addresses 0x030, 0x031, 0x032, each with web=0xF.
  - Required: dsp_* equal to the fields during exactly 3 EXE cycles per element; valid at cycle 16.
- inst[31]=0, or vlen=0 → valid at cycle 1, with bram0_enb, bram1_enb and dsp_* never asserted.
- ADDR_W=10, src0=0x3FE, dst=0x3FF, vlen=3 → reads 0x3FE, 0x3FF, 0x000 and writes 0x3FF, 0x000, 0x001.
- Drop en during EXE of element 1 with vlen=4:
  - Required: IDLE next cycle, no WRITE for element 1, valid never high.
  - Required: a new start then runs correctly from elem_idx 0.
- Assert rst_n=0 asynchronously mid-WRITE → all outputs 0 before the next clock edge; the state stays IDLE until en is seen after release.
- DSP_LAT=1, vlen=255 (LEN_W=8) → 765 cycles of activity, final write to dst_base+254, valid at cycle 766.

Source files
------------

// File: rtl/vec_controller_if.sv
// vec_controller_if: bundles the instruction/kick inputs and the BRAM/DSP
// control outputs of vec_controller.
//   master: drives en, inst, src0_base, src1_base, dst_base, vlen and
//           observes busy, valid, elem_idx and the BRAM/DSP controls.
//   slave : the controller side (directions mirrored).
interface vec_controller_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8,
    parameter int WE_W   = 4
);
    logic              en;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] src0_base;
    logic [ADDR_W-1:0] src1_base;
    logic [ADDR_W-1:0] dst_base;
    logic [LEN_W-1:0]  vlen;

    logic              busy;
    logic              valid;
    logic [LEN_W-1:0]  elem_idx;
    logic [ADDR_W-1:0] bram0_raddrb;
    logic              bram0_enb;
    logic [ADDR_W-1:0] bram1_addrb;
    logic [WE_W-1:0]   bram1_web;
    logic              bram1_enb;
    logic [3:0]        dsp_alumode;
    logic [6:0]        dsp_opmode;
    logic [4:0]        dsp_inmode;

    modport master (
        output en, inst, src0_base, src1_base, dst_base, vlen,
        input  busy, valid, elem_idx, bram0_raddrb, bram0_enb,
               bram1_addrb, bram1_web, bram1_enb,
               dsp_alumode, dsp_opmode, dsp_inmode
    );

    modport slave (
        input  en, inst, src0_base, src1_base, dst_base, vlen,
        output busy, valid, elem_idx, bram0_raddrb, bram0_enb,
               bram1_addrb, bram1_web, bram1_enb,
               dsp_alumode, dsp_opmode, dsp_inmode
    );
endinterface

// File: rtl/vec_controller.sv
// vec_controller: vector DSP instruction sequencer. On a kick (en=1 in
// IDLE) it captures one instruction, three base addresses and an element
// count, then runs READ -> EXE (DSP_LAT cycles) -> WRITE once per element
// with auto-incrementing BRAM addresses, and reports completion in DONE.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - vec_controller_if.slave: kick/instruction inputs, status
//           (busy, valid, elem_idx) and BRAM0/BRAM1/DSP48 control outputs
module vec_controller #(
    parameter int ADDR_W  = 10,
    parameter int LEN_W   = 8,
    parameter int DSP_LAT = 3,
    parameter int WE_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    vec_controller_if.slave    bus
);

    localparam int CNT_W = (DSP_LAT > 1) ? $clog2(DSP_LAT) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(DSP_LAT - 1);

    typedef enum logic [2:0] {IDLE, READ, EXE, WRITE, DONE} state_t;

    state_t            state, next_state;
    logic [3:0]        alumode_q;
    logic [6:0]        opmode_q;
    logic [4:0]        inmode_q;
    logic [ADDR_W-1:0] src0_q, src1_q, dst_q;
    logic [LEN_W-1:0]  vlen_q;
    logic [LEN_W-1:0]  elem_idx_q;
    logic [CNT_W-1:0]  lat_cnt_q;
    logic              last_elem;
    logic              inst_unused;

    // Instruction bits [14:0] carry no meaning for this controller.
    assign inst_unused = ^bus.inst[14:0];
    assign last_elem   = (elem_idx_q == vlen_q - LEN_W'(1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; dropping en anywhere but IDLE abandons the run.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    if (bus.inst[31] && (bus.vlen != '0)) begin
                        next_state = READ;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            READ: next_state = bus.en ? EXE : IDLE;
            EXE: begin
                if (!bus.en) begin
                    next_state = IDLE;
                end else if (lat_cnt_q == LAT_LAST) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (!bus.en) begin
                    next_state = IDLE;
                end else if (last_elem) begin
                    next_state = DONE;
                end else begin
                    next_state = READ;
                end
            end
            DONE: next_state = bus.en ? DONE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Captured operands and run counters. Everything is cleared on the way
    // back to IDLE so a fresh kick always starts from a clean context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alumode_q  <= '0;
            opmode_q   <= '0;
            inmode_q   <= '0;
            src0_q     <= '0;
            src1_q     <= '0;
            dst_q      <= '0;
            vlen_q     <= '0;
            elem_idx_q <= '0;
            lat_cnt_q  <= '0;
        end else if (next_state == IDLE) begin
            alumode_q  <= '0;
            opmode_q   <= '0;
            inmode_q   <= '0;
            src0_q     <= '0;
            src1_q     <= '0;
            dst_q      <= '0;
            vlen_q     <= '0;
            elem_idx_q <= '0;
            lat_cnt_q  <= '0;
        end else begin
            if (state == IDLE) begin
                alumode_q <= bus.inst[30:27];
                opmode_q  <= bus.inst[26:20];
                inmode_q  <= bus.inst[19:15];
                src0_q    <= bus.src0_base;
                src1_q    <= bus.src1_base;
                dst_q     <= bus.dst_base;
                vlen_q    <= bus.vlen;
            end
            if (state == EXE) begin
                lat_cnt_q <= (lat_cnt_q == LAT_LAST) ? '0 : lat_cnt_q + CNT_W'(1);
            end
            if ((state == WRITE) && (next_state == READ)) begin
                elem_idx_q <= elem_idx_q + LEN_W'(1);
            end
        end
    end

    // Output decode, purely from registered state and counters.
    always_comb begin
        bus.busy         = 1'b0;
        bus.valid        = 1'b0;
        bus.elem_idx     = elem_idx_q;
        bus.bram0_enb    = 1'b0;
        bus.bram0_raddrb = '0;
        bus.bram1_enb    = 1'b0;
        bus.bram1_web    = '0;
        bus.bram1_addrb  = '0;
        bus.dsp_alumode  = '0;
        bus.dsp_opmode   = '0;
        bus.dsp_inmode   = '0;
        case (state)
            READ: begin
                bus.busy         = 1'b1;
                bus.bram0_enb    = 1'b1;
                bus.bram0_raddrb = src0_q + ADDR_W'(elem_idx_q);
                bus.bram1_enb    = 1'b1;
                bus.bram1_addrb  = src1_q + ADDR_W'(elem_idx_q);
            end
            EXE: begin
                bus.busy        = 1'b1;
                bus.dsp_alumode = alumode_q;
                bus.dsp_opmode  = opmode_q;
                bus.dsp_inmode  = inmode_q;
            end
            WRITE: begin
                bus.busy        = 1'b1;
                bus.bram1_enb   = 1'b1;
                bus.bram1_web   = {WE_W{1'b1}};
                bus.bram1_addrb = dst_q + ADDR_W'(elem_idx_q);
            end
            DONE: bus.valid = 1'b1;
            default: ;
        endcase
    end

endmodule
